// File: rtl/crypt_pkg.sv
// crypt_pkg: shared types and constants for the crypt UART transmit path
package crypt_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  localparam int CLKS_PER_BIT_DEF = 868;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: first-word-fall-through synchronous FIFO
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  end
endmodule

// File: rtl/crypt_uart_tx.sv
// crypt_uart_tx: buffers crypt output bytes and sends them as 8N1 UART frames
module crypt_uart_tx
  import crypt_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic [7:0] data_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, next;
  logic alive, push, pop, full, empty, bit_end;
  logic [CW-1:0] count;
  byte_t dout, shift, shift_nxt;
  logic [15:0] cnt;
  logic [2:0] idx;
  assign ready_out = alive && !full;
  assign push = start_in && ready_out;
  assign busy = state != IDLE || count != '0;
  assign bit_end = cnt == LAST;
  byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(data_in),
    .dout(dout),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // a pop always lands in START, so a STOP-end pop chains frames with no gap
  always_comb begin
    pop = (state == IDLE || (state == STOP && bit_end)) && !empty;
    next = pop ? START
         : !bit_end ? state
         : state == START ? DATA
         : state == DATA ? (idx == 3'd7 ? STOP : DATA)
         : state == STOP ? IDLE : state;
    shift_nxt = pop ? dout : (state == DATA && bit_end) ? shift >> 1 : shift;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      alive <= 1'b0;
      overflow <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
    end else begin
      alive <= 1'b1;
      overflow <= overflow || (start_in && !ready_out);
      state <= next;
      cnt <= (state == IDLE || next != state || bit_end) ? '0 : cnt + 1'b1;
      idx <= pop ? '0 : (state == DATA && bit_end) ? idx + 1'b1 : idx;
      shift <= shift_nxt;
      tx <= next == START ? 1'b0 : next == DATA ? shift_nxt[0] : 1'b1;
    end
  end
endmodule

// File: tb/tb_crypt_uart_tx.sv
// tb_crypt_uart_tx: directed checks of crypt_uart_tx framing, buffering and reset
module tb_crypt_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0, rst = 1'b1, start_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic ready_out, tx, busy, overflow;
  int checks = 0, errors = 0;

  crypt_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .start_in(start_in),
    .data_in(data_in),
    .ready_out(ready_out),
    .tx(tx),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // offset i counts cycles from the first start-bit cycle of a frame
  task automatic check_bits(input logic [7:0] b, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      int k;
      logic e;
      k = i / CPB;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      check($sformatf("tx byte %0h off %0d", b, i), tx, e);
      @(negedge clk);
    end
  endtask

  task automatic idle_watch(input string tag, input int n);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check(tag, bad, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst tx", tx, 1'b1);
    check("rst ready", ready_out, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst overflow", overflow, 1'b0);
    rst = 1'b0;
    check("ready still low at release", ready_out, 1'b0);
    @(negedge clk);
    check("ready after release", ready_out, 1'b1);
    check("busy after release", busy, 1'b0);
    check("tx after release", tx, 1'b1);

    start_in = 1'b1; data_in = 8'hA5;
    @(negedge clk);
    start_in = 1'b0; data_in = 8'h00;
    check("a5 tx idle on accept", tx, 1'b1);
    check("a5 busy on accept", busy, 1'b1);
    @(negedge clk);
    check_bits(8'hA5, 0, 38);
    check("a5 busy in stop", busy, 1'b1);
    check_bits(8'hA5, 39, 39);
    check("a5 busy done", busy, 1'b0);
    check("a5 tx idle", tx, 1'b1);

    start_in = 1'b1; data_in = 8'h01;
    @(negedge clk); data_in = 8'h02;
    @(negedge clk); data_in = 8'h03;
    @(negedge clk); data_in = 8'h04;
    @(negedge clk); data_in = 8'h05;
    @(negedge clk); start_in = 1'b0;
    check("burst ready full", ready_out, 1'b0);
    check_bits(8'h01, 3, 39);
    check("burst ready recovers", ready_out, 1'b1);
    check_bits(8'h02, 0, 39);
    check_bits(8'h03, 0, 39);
    check_bits(8'h04, 0, 39);
    check_bits(8'h05, 0, 39);
    check("burst busy done", busy, 1'b0);
    check("burst overflow", overflow, 1'b0);

    start_in = 1'b1; data_in = 8'h11;
    @(negedge clk); data_in = 8'h12;
    @(negedge clk); data_in = 8'h13;
    @(negedge clk); data_in = 8'h14;
    @(negedge clk); data_in = 8'h15;
    @(negedge clk);
    check("ovf ready full", ready_out, 1'b0);
    check("ovf before pulse", overflow, 1'b0);
    data_in = 8'hFF;
    @(negedge clk); start_in = 1'b0;
    check("ovf set", overflow, 1'b1);
    check_bits(8'h11, 4, 39);
    check_bits(8'h12, 0, 39);
    check_bits(8'h13, 0, 39);
    check_bits(8'h14, 0, 39);
    check_bits(8'h15, 0, 39);
    check("ovf busy done", busy, 1'b0);
    idle_watch("ovf no ff frame", 50);
    check("ovf sticky", overflow, 1'b1);

    start_in = 1'b1; data_in = 8'h77;
    @(negedge clk); data_in = 8'h99;
    @(negedge clk); start_in = 1'b0;
    check_bits(8'h77, 0, 38);
    start_in = 1'b1; data_in = 8'h3C;
    check_bits(8'h77, 39, 39);
    start_in = 1'b0;
    check("pushpop ready", ready_out, 1'b1);
    check_bits(8'h99, 0, 39);
    check_bits(8'h3C, 0, 39);
    check("pushpop busy done", busy, 1'b0);

    start_in = 1'b1; data_in = 8'h55;
    @(negedge clk); data_in = 8'hAA;
    @(negedge clk); data_in = 8'h0F;
    @(negedge clk); start_in = 1'b0;
    check_bits(8'h55, 1, 17);
    rst = 1'b1;
    @(negedge clk);
    check("midrst tx", tx, 1'b1);
    check("midrst ready", ready_out, 1'b0);
    check("midrst busy", busy, 1'b0);
    check("midrst overflow cleared", overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst ready after release", ready_out, 1'b1);
    idle_watch("midrst no frames", 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
